// File: rtl/fdc_sd_arbiter.sv
// Round-robin arbiter sharing one SD block-device channel among four WD1793 drives.
// Optional ISSUE ack-wait timeout enabled by defining FDC_ARB_TIMEOUT_EN.
module fdc_sd_arbiter #(
  parameter int unsigned NUM_DRIVES = 4
`ifdef FDC_ARB_TIMEOUT_EN
  , parameter logic [23:0] TIMEOUT_CYC = 24'd8_000_000
`endif
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [3:0]    REQ_RD,
  input  logic [3:0]    REQ_WR,
  input  logic [127:0]  REQ_LBA,
  input  logic [31:0]   REQ_BUFF_DIN,
  output logic [3:0]    REQ_ACK,
  output logic [3:0]    REQ_BUFF_WR,
  output logic [3:0]    REQ_ERR,
  output logic [31:0]   SD_LBA,
  output logic          SD_RD,
  output logic          SD_WR,
  input  logic          SD_ACK,
  input  logic          SD_BUFF_WR,
  output logic [7:0]    SD_BUFF_DIN,
  output logic [1:0]    GRANT,
  output logic          BUSY
);

  localparam int unsigned GW     = 2;
  localparam int unsigned LBA_W  = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_XFER  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;
  logic              sd_rd_q, sd_rd_d;
  logic              sd_wr_q, sd_wr_d;
  logic [LBA_W-1:0]  sd_lba_q, sd_lba_d;

  logic [3:0]        req_any_c;
  logic [GW-1:0]     cand_c;
  logic [GW-1:0]     pick_c;
  logic              pick_vld_c;

`ifdef FDC_ARB_TIMEOUT_EN
  logic [23:0]       cnt_q, cnt_d;
  logic [3:0]        req_err_q, req_err_d;
`endif

  assign req_any_c = REQ_RD | REQ_WR;

  // Rotating priority: first requester after the last served drive wins.
  always_comb begin
    cand_c     = last_grant_q;
    pick_c     = last_grant_q;
    pick_vld_c = 1'b0;
    for (int unsigned i = 1; i <= NUM_DRIVES; i++) begin
      cand_c = last_grant_q + GW'(i);
      if (!pick_vld_c && req_any_c[cand_c]) begin
        pick_c     = cand_c;
        pick_vld_c = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    sd_rd_d      = sd_rd_q;
    sd_wr_d      = sd_wr_q;
    sd_lba_d     = sd_lba_q;
`ifdef FDC_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    req_err_d    = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_vld_c) begin
          grant_d  = pick_c;
          sd_rd_d  = REQ_RD[pick_c];
          sd_wr_d  = ~REQ_RD[pick_c];
          sd_lba_d = REQ_LBA[{pick_c, 5'b00000} +: LBA_W];
          state_d  = S_ISSUE;
`ifdef FDC_ARB_TIMEOUT_EN
          cnt_d    = 24'd0;
`endif
        end
      end
      S_ISSUE: begin
        // Once issued, the request is held until the host answers.
        if (SD_ACK) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = S_XFER;
        end
`ifdef FDC_ARB_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CYC - 24'd1) begin
          sd_rd_d            = 1'b0;
          sd_wr_d            = 1'b0;
          req_err_d[grant_q] = 1'b1;
          state_d            = S_DONE;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
`endif
      end
      S_XFER: begin
        if (!SD_ACK) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(3);
      sd_rd_q      <= 1'b0;
      sd_wr_q      <= 1'b0;
      sd_lba_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      sd_rd_q      <= sd_rd_d;
      sd_wr_q      <= sd_wr_d;
      sd_lba_q     <= sd_lba_d;
    end
  end

`ifdef FDC_ARB_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q     <= '0;
      req_err_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      req_err_q <= req_err_d;
    end
  end

  assign REQ_ERR = req_err_q;
`else
  assign REQ_ERR = '0;
`endif

  // Ack and buffer strobes reach only the granted drive.
  always_comb begin
    REQ_ACK     = '0;
    REQ_BUFF_WR = '0;
    if (state_q == S_ISSUE || state_q == S_XFER) begin
      REQ_ACK[grant_q] = SD_ACK;
    end
    if (state_q == S_XFER) begin
      REQ_BUFF_WR[grant_q] = SD_BUFF_WR;
    end
  end

  assign SD_BUFF_DIN = REQ_BUFF_DIN[{grant_q, 3'b000} +: BYTE_W];
  assign SD_LBA      = sd_lba_q;
  assign SD_RD       = sd_rd_q;
  assign SD_WR       = sd_wr_q;
  assign GRANT       = grant_q;
  assign BUSY        = (state_q != S_IDLE);

endmodule

// File: doc/fdc_sd_arbiter.md
Name: fdc_sd_arbiter

Overview:
- Shares one MiSTer SD block-device channel among the four per-drive WD1793 instances in the floppy subsystem.
- Each drive presents its own sd_rd/sd_wr/sd_lba request and buffer signals. The arbiter grants one drive at a time, round-robin.
- The granted drive's request is forwarded to the host channel and held until the host transfer completes.
- The 512-byte buffer byte stream is steered to and from the granted drive only.

Parameters:
- NUM_DRIVES, 4, number of requesting drive controllers (fixed at 4 in this revision; grant index is 2 bits).
- TIMEOUT_CYC, 24'd8_000_000, ack-wait limit in CLK cycles; used only when FDC_ARB_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ_RD  in  4  per-drive read request (drive n = bit n).
- REQ_WR  in  4  per-drive write request.
- REQ_LBA  in  128  per-drive LBA; drive n at [32n+31:32n].
- REQ_BUFF_DIN  in  32  per-drive buffer read-back byte; drive n at [8n+7:8n].
- REQ_ACK  out  4  per-drive ack, a copy of SD_ACK on the granted bit only.
- REQ_BUFF_WR  out  4  per-drive buffer write strobe.
- REQ_ERR  out  4  per-drive timeout pulse (optional feature only; tied 0 otherwise).
- SD_LBA  out  32  host LBA.
- SD_RD  out  1  host read request.
- SD_WR  out  1  host write request.
- SD_ACK  in  1  host ack.
- SD_BUFF_WR  in  1  host buffer write strobe.
- SD_BUFF_DIN  out  8  byte to host (write path).
- GRANT  out  2  current granted drive index.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, last_grant = 3 (so drive 0 has first priority after reset).
- Reset asserted mid-transfer: SD_RD/SD_WR drop asynchronously and the transfer is abandoned with no completion ack.
- IDLE:
  - Scan drives last_grant+1, +2, +3, +4 (mod 4); the first n with REQ_RD[n] | REQ_WR[n] wins.
  - Latch GRANT=n, op=read if REQ_RD[n] else write (read wins if both are set), and SD_LBA = REQ_LBA[n].
  - Go to ISSUE. SD_RD or SD_WR is registered high in the cycle after the request is sampled (1-cycle latency).
- ISSUE:
  - Hold SD_RD/SD_WR and SD_LBA stable.
  - On SD_ACK=1: drop SD_RD/SD_WR and go to XFER.
  - If the granted requester deasserts before the ack, the request is still held until SD_ACK. A request is never cancelled once issued.
- XFER:
  - REQ_BUFF_WR[GRANT] = SD_BUFF_WR (combinational); all other drives' strobes are 0.
  - On SD_ACK=0: go to DONE.
- REQ_ACK[GRANT] = SD_ACK during ISSUE and XFER (combinational); all other bits are 0.
- SD_BUFF_DIN = REQ_BUFF_DIN byte of GRANT in every state (combinational mux).
- DONE:
  - One cycle; last_grant <= GRANT; go to IDLE.
  - A requester still asserting in IDLE is re-arbitrated as a new request. Requesters must drop their request on seeing their ack (WD1793 does this).
- Fairness: a continuously requesting drive waits at most 3 other transfers.
- Requests are accepted only in IDLE; requests arriving during BUSY stay pending (level-sensitive).
- SD_BUFF_WR outside XFER is ignored (no strobe reaches any drive).

Optional Feature:
- FDC_ARB_TIMEOUT_EN defined:
  - A 24-bit counter clears on entry to ISSUE and increments each cycle in ISSUE.
  - On reaching TIMEOUT_CYC with SD_ACK still 0: drop SD_RD/SD_WR, pulse REQ_ERR[GRANT] for 1 cycle, go to DONE.
  - A late SD_ACK arriving in IDLE is ignored.
- Not defined:
  - No counter; ISSUE waits for SD_ACK indefinitely; REQ_ERR is tied to 0.

Test Plan:
- Single read:
  - Stimulus: after reset, REQ_RD=4'b0010, REQ_LBA[1]=32'h123.
  - Required: next cycle SD_RD=1, SD_LBA=32'h123, GRANT=1, BUSY=1.
  - Stimulus: SD_ACK high 3 cycles then low.
  - Required: REQ_ACK=4'b0010 for those 3 cycles; DONE; IDLE 1 cycle later.
- Round-robin:
  - Stimulus: REQ_RD=4'b1111 held, each transfer completed by the host.
  - Required: grant order 0,1,2,3,0.
  - Stimulus: hold drive 2 only, after last_grant=2.
  - Required: drive 2 is re-granted.
- Write buffer steering:
  - Stimulus: REQ_WR=4'b0100, REQ_BUFF_DIN drive-2 byte = 8'hA5.
  - Required: SD_WR=1, SD_BUFF_DIN=8'hA5.
  - Stimulus: SD_BUFF_WR pulses during XFER.
  - Required: only REQ_BUFF_WR[2] pulses; pulses in IDLE produce no strobe.
- Read/write same drive:
  - Stimulus: REQ_RD[3]=REQ_WR[3]=1.
  - Required: SD_RD=1, SD_WR=0.
- Reset mid-XFER:
  - Stimulus: assert RESET while SD_ACK=1.
  - Required: SD_RD, SD_WR, REQ_ACK, BUSY all 0 immediately; the next request from any drive starts arbitration at drive 0.
- Timeout (FDC_ARB_TIMEOUT_EN defined, TIMEOUT_CYC=16):
  - Stimulus: REQ_RD[0], SD_ACK never asserted.
  - Required: SD_RD high 16 cycles, then 0; REQ_ERR=4'b0001 for 1 cycle; BUSY drops 1 cycle later.
